// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the arithmetic datapath: field slices, constants
// and the divider controller state encoding.
package fp16_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam logic [14:0] FP16_INF = 15'h7C00;
    localparam logic [14:0] FP16_ONE = 15'h3C00;

    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_MANT_MSB = 9;
    localparam int FP16_MANT_LSB = 0;

    typedef logic [1:0] fdiv_state_t;
    localparam fdiv_state_t ST_IDLE   = 2'd0;
    localparam fdiv_state_t ST_DIVIDE = 2'd1;
    localparam fdiv_state_t ST_NORM   = 2'd2;
    localparam fdiv_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/fdiv_seq_if.sv
// Start/done handshake and operand/result bus of the sequential fp16 divider.
interface fdiv_seq_if;

    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, A, B,
        input  result, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output result, busy, done, div_by_zero, overflow
    );

endinterface

// File: rtl/fdiv_mant_core.sv
// Restoring mantissa divider: one quotient bit per step, q = floor(ma*2^11/mb)
// after twelve steps.
module fdiv_mant_core #(
    parameter int QBITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [10:0] ma_i,
    input  logic [10:0] mb_i,
    output logic [11:0] q_o,
    output logic        last_o
);

    logic [11:0] rem_q, rem_d;
    logic [11:0] q_q, q_d;
    logic [10:0] mb_q, mb_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ge;
    logic [11:0] diff;

    // The restored remainder is always below mb (< 2^11), so the shift fits 12 bits.
    always_comb begin
        rem_d = rem_q;
        q_d   = q_q;
        mb_d  = mb_q;
        cnt_d = cnt_q;
        ge    = (rem_q >= {1'b0, mb_q});
        diff  = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        if (load_i) begin
            rem_d = {1'b0, ma_i};
            mb_d  = mb_i;
            q_d   = 12'd0;
            cnt_d = 4'd0;
        end else if (step_i) begin
            rem_d = {diff[10:0], 1'b0};
            q_d   = {q_q[10:0], ge};
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= 12'd0;
            q_q   <= 12'd0;
            mb_q  <= 11'd0;
            cnt_q <= 4'd0;
        end else begin
            rem_q <= rem_d;
            q_q   <= q_d;
            mb_q  <= mb_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o    = q_q;
    assign last_o = (cnt_q == 4'(QBITS - 1));

endmodule

// File: rtl/fdiv_seq.sv
// Sequential fp16 divider: controller, special-case detection, exponent
// arithmetic and normalization around the restoring mantissa core.
module fdiv_seq
    import fp16_pkg::*;
#(
    parameter int QBITS = 12,
    parameter int BIAS  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    fdiv_seq_if.slave  bus
);

    fdiv_state_t state_q, state_d;
    logic        sign_q, sign_d;
    logic [4:0]  ea_q, ea_d;
    logic [4:0]  eb_q, eb_d;
    logic        special_q, special_d;
    logic [15:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;

    logic        coreLoad;
    logic        coreStep;
    logic        coreLast;
    logic [11:0] q;
    logic        startSign;
    logic signed [6:0] eNorm;
    logic [9:0]  mantNorm;

    fdiv_mant_core #(.QBITS(QBITS)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (coreLoad),
        .step_i (coreStep),
        .ma_i   ({1'b1, bus.A[FP16_MANT_MSB:FP16_MANT_LSB]}),
        .mb_i   ({1'b1, bus.B[FP16_MANT_MSB:FP16_MANT_LSB]}),
        .q_o    (q),
        .last_o (coreLast)
    );

    assign startSign = bus.A[FP16_SIGN_BIT] ^ bus.B[FP16_SIGN_BIT];

    // A quotient without its top bit set means ma < mb, costing one exponent step.
    always_comb begin
        mantNorm = q[11] ? q[10:1] : q[9:0];
        eNorm    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                 + $signed(7'(BIAS)) - $signed({6'd0, ~q[11]});
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        special_d = special_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        coreLoad  = 1'b0;
        coreStep  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d    = 1'b1;
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    sign_d    = startSign;
                    ea_d      = bus.A[FP16_EXP_MSB:FP16_EXP_LSB];
                    eb_d      = bus.B[FP16_EXP_MSB:FP16_EXP_LSB];
                    special_d = 1'b1;
                    state_d   = ST_NORM;
                    if (bus.A[FP16_EXP_MSB:FP16_EXP_LSB] == 5'd0) begin
                        result_d = 16'h0000;
                    end else if (bus.B[FP16_EXP_MSB:FP16_EXP_LSB] == 5'd0) begin
                        result_d = {startSign, FP16_INF};
                        dbz_d    = 1'b1;
                    end else begin
                        special_d = 1'b0;
                        coreLoad  = 1'b1;
                        state_d   = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                coreStep = 1'b1;
                if (coreLast) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (!special_q) begin
                    if (eNorm >= $signed(7'(FP16_EXP_MAX))) begin
                        result_d = {sign_q, FP16_INF};
                        ovf_d    = 1'b1;
                    end else if (eNorm <= 7'sd0) begin
                        result_d = 16'h0000;
                    end else begin
                        result_d = {sign_q, eNorm[4:0], mantNorm};
                    end
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            ea_q      <= 5'd0;
            eb_q      <= 5'd0;
            special_q <= 1'b0;
            result_q  <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            ea_q      <= ea_d;
            eb_q      <= eb_d;
            special_q <= special_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed cases plus random operands checked
// against an arithmetic reference of the fp16 divide rules.
module tb_fdiv_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fdiv_seq_if bus ();

    fdiv_seq #(.QBITS(12), .BIAS(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: integer quotient of the full mantissas, then the fp16 packing rules.
    function automatic void refDiv(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] res, output logic dbz,
                                   output logic ovf, output int lat);
        int ea, eb, ma, mb, qv, e, mant;
        logic s;
        ea   = int'(a[14:10]);
        eb   = int'(b[14:10]);
        ma   = 1024 + int'(a[9:0]);
        mb   = 1024 + int'(b[9:0]);
        s    = a[15] ^ b[15];
        dbz  = 1'b0;
        ovf  = 1'b0;
        if (ea == 0) begin
            res = 16'h0000;
            lat = 2;
        end else if (eb == 0) begin
            res = {s, 15'h7C00};
            dbz = 1'b1;
            lat = 2;
        end else begin
            lat = 14;
            qv  = (ma * 2048) / mb;
            if (qv >= 2048) begin
                mant = (qv / 2) % 1024;
                e    = ea - eb + 15;
            end else begin
                mant = qv % 1024;
                e    = ea - eb + 14;
            end
            if (e >= 31) begin
                res = {s, 15'h7C00};
                ovf = 1'b1;
            end else if (e <= 0) begin
                res = 16'h0000;
            end else begin
                res = {s, 5'(e), 10'(mant)};
            end
        end
    endfunction

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input int pulseAt, input bit startAtDone, input string tag);
        logic [15:0] expRes;
        logic        expDbz, expOvf;
        int          expLat, cyc, busyLow;
        refDiv(a, b, expRes, expDbz, expOvf, expLat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        cyc       = 1;
        busyLow   = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy !== 1'b1) busyLow++;
            bus.start = (cyc == pulseAt);
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        checkOutput({tag, " latency"}, 32'(cyc), 32'(expLat));
        checkOutput({tag, " busyLowInFlight"}, 32'(busyLow), 32'd0);
        checkOutput({tag, " busyAtDone"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " result"}, 32'(bus.result), 32'(expRes));
        checkOutput({tag, " divByZero"}, 32'(bus.div_by_zero), 32'(expDbz));
        checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'(expOvf));
        if (startAtDone) begin
            bus.start = 1'b1;
            bus.A     = 16'h4200;
            bus.B     = 16'h4000;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput({tag, " donePulseEnds"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " idleAfter"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " resultHeld"}, 32'(bus.result), 32'(expRes));
    endtask

    task automatic checkOutputsCleared(input string tag);
        checkOutput({tag, " result"}, 32'(bus.result), 32'd0);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " divByZero"}, 32'(bus.div_by_zero), 32'd0);
        checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        int doneSeen;
        logic [15:0] ra, rb;
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutputsCleared("reset");
        rst_n = 1'b1;

        applyStimulus(16'h4200, 16'h4000, 0, 1'b0, "3div2");
        applyStimulus(16'h3C00, 16'h4200, 0, 1'b0, "1div3");
        applyStimulus(16'hC200, 16'h4000, 0, 1'b0, "neg3div2");
        applyStimulus(16'h0000, 16'h4000, 0, 1'b0, "zeroDividend");
        applyStimulus(16'h3C00, 16'h0000, 0, 1'b0, "divByZero");
        applyStimulus(16'hBC00, 16'h8000, 0, 1'b0, "negDivByZero");
        applyStimulus(16'h7800, 16'h0400, 0, 1'b0, "overflow");
        applyStimulus(16'h0400, 16'h7800, 5, 1'b0, "underflowBusyStart");
        applyStimulus(16'h3C00, 16'h4200, 0, 1'b1, "startInDone");

        // Abort an operation mid-divide; no done may follow.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h4200;
        bus.B     = 16'h4000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutputsCleared("midReset");
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) doneSeen++;
        end
        checkOutput("midReset noDone", 32'(doneSeen), 32'd0);
        applyStimulus(16'h4200, 16'h4000, 0, 1'b0, "afterReset");

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra[14:10] = 5'd0;
            if ($urandom_range(0, 7) == 0) rb[14:10] = 5'd0;
            applyStimulus(ra, rb, 0, 1'b0, $sformatf("rand%0d_%h_%h", n, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
